// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a byte FIFO and serialises each byte
// as a UART frame (start, 8 data LSB first, opt. parity, stop).
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_pop,
  output logic       tx,
  output logic       busy,
  output logic       byte_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, POP, LOAD, START, DATA, PAR, STOP
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic          parity;
  logic          baud_end;

  assign baud_end = (baud_cnt == BAUD_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      parity    <= 1'b0;
      tx        <= 1'b1;
      fifo_pop  <= 1'b0;
      busy      <= 1'b0;
      byte_done <= 1'b0;
    end else begin
      fifo_pop  <= 1'b0;
      byte_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state    <= POP;
            fifo_pop <= 1'b1;
            busy     <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
        end
        LOAD: begin
          shift_reg <= fifo_dout;
          if (PARITY == 2)
            parity <= ~^fifo_dout;
          else if (PARITY == 1)
            parity <= ^fifo_dout;
          else
            parity <= 1'b0;
          baud_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift_reg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                tx    <= parity;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PAR: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          // bit_cnt counts completed stop bits here
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_cnt == STOP_MAX) begin
              bit_cnt   <= '0;
              busy      <= 1'b0;
              byte_done <= 1'b1;
              state     <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Serial transmitter that sits directly downstream of the 8-deep byte FIFO and drains it.
- Pops one byte at a time, waits for the FIFO's registered read data, then serialises it as an asynchronous UART frame on `tx`.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Used wherever buffered bytes must leave the chip over a UART line.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (868 gives 115200 baud at 100 MHz); must be >= 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) resets immediately, release is synchronous to clk.
- enable  input  1  when 1, the block may start new frames; a frame in progress always completes.
- fifo_empty  input  1  FIFO empty flag.
- fifo_dout  input  8  FIFO read data; valid the cycle after a pop.
- fifo_pop  output  1  one-cycle pop request to the FIFO.
- tx  output  1  serial line; idle high.
- busy  output  1  1 whenever state is not IDLE.
- byte_done  output  1  one-cycle pulse when a frame's last stop bit has ended.

Behaviour:
- Reset values (asynchronous, while reset = 0): tx = 1, fifo_pop = 0, busy = 0, byte_done = 0, state = IDLE, all counters = 0.
- Internal state: bit counter (3 bits), baud counter ($clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1), 8-bit shift register, parity register.
- All outputs are registered.
- States: IDLE, POP, LOAD, START, DATA, PAR, STOP.
- IDLE: tx = 1.
  - If enable = 1 and fifo_empty = 0 -> POP.
- POP: exactly one cycle.
  - fifo_pop = 1 during this cycle and 0 in every other state.
  - Always -> LOAD.
- LOAD: one cycle; fifo_dout is valid here.
  - On the exiting edge, capture fifo_dout into the shift register.
  - Compute parity = ^fifo_dout for PARITY = 1, ~^fifo_dout for PARITY = 2.
  - -> START.
- START: tx = 0 for CLKS_PER_BIT cycles -> DATA.
- DATA: tx = shift_reg[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - After 8 bits -> PAR if PARITY != 0, else STOP.
- PAR: tx = parity bit for CLKS_PER_BIT cycles -> STOP.
- STOP: tx = 1 for STOP_BITS * CLKS_PER_BIT cycles -> IDLE.
  - byte_done = 1 during the first IDLE cycle after STOP.
- Latency: if IDLE sees the start condition in cycle N, then fifo_pop = 1 in N+1 and tx falls at N+3.
- Frame length: CLKS_PER_BIT * (9 + (PARITY != 0) + STOP_BITS) cycles from tx falling to the end of the stop bits.
- Back-to-back frames: with the FIFO non-empty and enable held, tx stays high for exactly 3 cycles (IDLE, POP, LOAD) between the end of one stop period and the next start bit.
- enable deasserted mid-frame: the current frame finishes unchanged; no further pop occurs until enable returns to 1 in IDLE.
- fifo_empty is sampled only in IDLE; changes to it in other states are ignored.
- No pop is ever issued while fifo_empty = 1.
- Reset mid-frame: tx returns to 1 immediately; the frame is abandoned and the byte is not retransmitted.
- The baud counter restarts at 0 on entry to each bit period; there is no fractional-baud correction.

Test Plan:
(all with CLKS_PER_BIT = 4)
- Single byte, PARITY = 0, STOP_BITS = 1:
  - Stimulus: FIFO holds 0xA5, enable = 1.
  - Required: fifo_pop high for exactly 1 cycle; tx falls 2 cycles later.
  - Required: tx bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 cycles (40 cycles total).
  - Required: byte_done pulses once in the first IDLE cycle after the stop bit; busy = 0 afterwards.
- Back-to-back:
  - Stimulus: FIFO holds 0x01 then 0x80.
  - Required: two pops; exactly 3 high cycles on tx between the first stop end and the second start.
  - Required: second data sequence 0,0,0,0,0,0,0,1; two byte_done pulses.
- Parity, byte 0x07:
  - PARITY = 1: parity bit = 1; frame is 44 cycles.
  - PARITY = 2: parity bit = 0.
  - STOP_BITS = 2 with PARITY = 0: stop period is 8 cycles; frame is 44 cycles.
- Enable gating:
  - Stimulus: FIFO holds 3 bytes; drop enable during data bit 3 of byte 1.
  - Required: byte 1 completes, no second pop, tx stays 1.
  - Required: raising enable again starts byte 2 with its pop 1 cycle later.
- Reset mid-frame:
  - Stimulus: assert reset = 0 during DATA bit 5, between clock edges.
  - Required: tx = 1, busy = 0, fifo_pop = 0 without waiting for a clock edge.
  - Required: after release with fifo_empty = 1, the block stays IDLE with no pop.
- Empty FIFO:
  - Stimulus: enable = 1, fifo_empty = 1 for 100 cycles.
  - Required: fifo_pop, busy and byte_done stay 0; tx stays 1.
